// File: rtl/layer_seq_ctrl.sv
// Sequencer for one dense layer: loads N x-words, then runs M rows of N MACs plus bias and ReLU.
// Latency: row 0 result valid N+2 edges after the last x accept, then one row per N+2 cycles.
// Backpressure: x accepted only in LOAD; a held output register stalls the FSM in WRITE/DONE.
module layer_seq_ctrl #(
  parameter int M    = 13,
  parameter int N    = 16,
  parameter int logN = $clog2(N),
  parameter int logM = $clog2(M),
  parameter int logW = $clog2(M*N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_valid,
  output logic            s_ready,
  output logic            m_valid,
  input  logic            m_ready,
  output logic            wr_en_x,
  output logic [logN-1:0] addr_x,
  output logic [logW-1:0] addr_w,
  output logic [logM-1:0] addr_b,
  output logic            clear_acc,
  output logic            acc_en,
  output logic            wr_en_y,
  output logic            busy
);

  typedef enum logic [2:0] {LOAD, MAC, FLUSH, WRITE, DONE} state_t;

  localparam logic [logN-1:0] K_LAST   = logN'(N-1);
  localparam logic [logM-1:0] ROW_LAST = logM'(M-1);

  state_t          state, state_nxt;
  logic [logN-1:0] ld_ptr, ld_ptr_nxt;
  logic [logN-1:0] k, k_nxt;
  logic [logM-1:0] row, row_nxt;
  logic            out_free;

  // s_ready is gated by reset so no word is offered while the block is held in reset.
  assign s_ready  = reset && (state == LOAD);
  assign wr_en_x  = s_valid && s_ready;
  assign busy     = (state != LOAD);
  assign out_free = !m_valid || m_ready;

  // k parks at N-1 through FLUSH/WRITE, so every address stays in range and holds on a stall.
  assign addr_x = (state == LOAD) ? ld_ptr : k;
  assign addr_b = row;
  assign addr_w = logW'(row) * logW'(N) + logW'(k);

  always_comb begin
    state_nxt  = state;
    ld_ptr_nxt = ld_ptr;
    k_nxt      = k;
    row_nxt    = row;
    wr_en_y    = 1'b0;
    case (state)
      LOAD: begin
        if (wr_en_x) begin
          if (ld_ptr == K_LAST) begin
            ld_ptr_nxt = '0;
            k_nxt      = '0;
            row_nxt    = '0;
            state_nxt  = MAC;
          end else begin
            ld_ptr_nxt = ld_ptr + logN'(1);
          end
        end
      end
      MAC: begin
        if (k == K_LAST) state_nxt = FLUSH;
        else             k_nxt     = k + logN'(1);
      end
      FLUSH: state_nxt = WRITE;
      WRITE: begin
        if (out_free) begin
          wr_en_y = 1'b1;
          k_nxt   = '0;
          if (row == ROW_LAST) begin
            row_nxt   = '0;
            state_nxt = DONE;
          end else begin
            row_nxt   = row + logM'(1);
            state_nxt = MAC;
          end
        end
      end
      DONE: begin
        if (out_free) begin
          ld_ptr_nxt = '0;
          state_nxt  = LOAD;
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= LOAD;
      ld_ptr    <= '0;
      k         <= '0;
      row       <= '0;
      acc_en    <= 1'b0;
      clear_acc <= 1'b0;
      m_valid   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ld_ptr    <= ld_ptr_nxt;
      k         <= k_nxt;
      row       <= row_nxt;
      // Delayed one cycle to line up with the registered ROM / x-memory read data.
      acc_en    <= (state == MAC);
      clear_acc <= (state == MAC) && (k == '0);
      if (wr_en_y)      m_valid <= 1'b1;
      else if (m_ready) m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Directed bench for layer_seq_ctrl: a 13x16 instance with a behavioural datapath, plus a 2x3 instance.
module tb_layer_seq_ctrl;

  localparam int M = 13, N = 16;
  localparam int LN = $clog2(N), LM = $clog2(M), LW = $clog2(M*N);
  localparam int MS = 2, NS = 3;
  localparam int LNS = $clog2(NS), LMS = $clog2(MS), LWS = $clog2(MS*NS);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, s_valid, m_ready;
  logic          s_ready, m_valid, wr_en_x, clear_acc, acc_en, wr_en_y, busy;
  logic [LN-1:0] addr_x;
  logic [LW-1:0] addr_w;
  logic [LM-1:0] addr_b;

  logic           reset_s, s_valid_s, m_ready_s;
  logic           s_ready_s, m_valid_s, wr_en_x_s, clear_acc_s, acc_en_s, wr_en_y_s, busy_s;
  logic [LNS-1:0] addr_x_s;
  logic [LWS-1:0] addr_w_s;
  logic [LMS-1:0] addr_b_s;

  layer_seq_ctrl #(.M(M), .N(N)) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .m_valid(m_valid), .m_ready(m_ready), .wr_en_x(wr_en_x), .addr_x(addr_x),
    .addr_w(addr_w), .addr_b(addr_b), .clear_acc(clear_acc), .acc_en(acc_en),
    .wr_en_y(wr_en_y), .busy(busy)
  );

  layer_seq_ctrl #(.M(MS), .N(NS)) dut_s (
    .clk(clk), .reset(reset_s), .s_valid(s_valid_s), .s_ready(s_ready_s),
    .m_valid(m_valid_s), .m_ready(m_ready_s), .wr_en_x(wr_en_x_s), .addr_x(addr_x_s),
    .addr_w(addr_w_s), .addr_b(addr_b_s), .clear_acc(clear_acc_s), .acc_en(acc_en_s),
    .wr_en_y(wr_en_y_s), .busy(busy_s)
  );

  int vectors = 0, miscompares = 0;
  int nacc;
  int s_dat;
  int xcur [N];

  // Behavioural memories and accumulator, steered only by the DUT's control outputs.
  int xmem [N];
  int x_q, w_q, b_q, acc, y;

  function automatic int w_rom(int a);
    return ((a * 7) % 11) - 5;
  endfunction

  function automatic int b_rom(int r);
    return r * 4 - 6;
  endfunction

  function automatic int y_exp(int r);
    int s = b_rom(r);
    for (int j = 0; j < N; j++) s += xcur[j] * w_rom(r * N + j);
    return (s < 0) ? 0 : s;
  endfunction

  task automatic set_x(int seed);
    for (int j = 0; j < N; j++) xcur[j] = ((j * 5 + seed) % 13) - 4;
  endtask

  always @(posedge clk) begin
    if (wr_en_x) xmem[addr_x] <= s_dat;
    x_q <= xmem[addr_x];
    w_q <= w_rom(int'(addr_w));
    b_q <= b_rom(int'(addr_b));
    if (clear_acc)   acc <= b_q + x_q * w_q;
    else if (acc_en) acc <= acc + x_q * w_q;
    if (wr_en_y) y <= (acc < 0) ? 0 : acc;
  end

  task automatic apply_reset();
    reset   = 1'b0;
    s_valid = 1'b0;
    m_ready = 1'b0;
    nacc    = 0;
    s_dat   = 0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; s_valid = 1'b1; m_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    vectors++; if (s_ready !== 1'b0 || wr_en_x !== 1'b0) begin miscompares++;
      $display("FAIL reset_handshake: s_ready=%b wr_en_x=%b want 0 0", s_ready, wr_en_x); end
    vectors++; if (busy !== 1'b0 || m_valid !== 1'b0 || wr_en_y !== 1'b0) begin miscompares++;
      $display("FAIL reset_status: busy=%b m_valid=%b wr_en_y=%b want 0 0 0", busy, m_valid, wr_en_y); end
    vectors++; if (addr_x !== '0 || addr_w !== '0 || addr_b !== '0) begin miscompares++;
      $display("FAIL reset_addr: x=%0d w=%0d b=%0d want 0 0 0", addr_x, addr_w, addr_b); end
    vectors++; if (clear_acc !== 1'b0 || acc_en !== 1'b0) begin miscompares++;
      $display("FAIL reset_acc: clear_acc=%b acc_en=%b want 0 0", clear_acc, acc_en); end
  endtask

  task automatic test_full_run();
    int ca = -1, cv = -1, nhs = 0, last_hs = -1, nrow5 = 0;
    bit finished = 0;
    apply_reset();
    set_x(1);
    m_ready = 1'b1;
    for (int i = 0; i < 320; i++) begin
      s_valid = 1'b1;
      s_dat   = (nacc < N) ? xcur[nacc] : 0;
      #1;
      if (nhs == M && i == last_hs + 1) begin
        vectors++; if (busy !== 1'b0 || s_ready !== 1'b1) begin miscompares++;
          $display("FAIL run_busy_fall: busy=%b s_ready=%b want 0 1", busy, s_ready); end
        vectors++; if (nacc !== N) begin miscompares++;
          $display("FAIL run_accepts: got %0d want %0d", nacc, N); end
        vectors++; if (nrow5 !== 18) begin miscompares++;
          $display("FAIL row5_len: got %0d cycles want 18", nrow5); end
        finished = 1;
        break;
      end
      if (wr_en_x) begin
        vectors++; if (int'(addr_x) !== nacc) begin miscompares++;
          $display("FAIL run_load_addr: got %0d want %0d", addr_x, nacc); end
        nacc++;
        ca = i;
      end
      if (busy && int'(addr_b) == 5) begin
        vectors++; if (int'(addr_w) !== ((nrow5 < 16) ? 80 + nrow5 : 95)) begin miscompares++;
          $display("FAIL row5_addr_w[%0d]: got %0d want %0d", nrow5, addr_w, (nrow5 < 16) ? 80 + nrow5 : 95); end
        vectors++; if (clear_acc !== (nrow5 == 1) || acc_en !== (nrow5 >= 1 && nrow5 <= 16)) begin miscompares++;
          $display("FAIL row5_ctrl[%0d]: clear_acc=%b acc_en=%b", nrow5, clear_acc, acc_en); end
        nrow5++;
      end
      if (m_valid && cv < 0) begin
        cv = i;
        vectors++; if (cv - ca - 1 !== N + 2) begin miscompares++;
          $display("FAIL run_latency: got %0d edges want %0d", cv - ca - 1, N + 2); end
      end
      if (m_valid && m_ready) begin
        vectors++; if (y !== y_exp(nhs)) begin miscompares++;
          $display("FAIL run_y[%0d]: got %0d want %0d", nhs, y, y_exp(nhs)); end
        if (nhs > 0) begin
          vectors++; if (i - last_hs !== N + 2) begin miscompares++;
            $display("FAIL run_spacing[%0d]: got %0d want %0d", nhs, i - last_hs, N + 2); end
        end
        last_hs = i;
        nhs++;
      end
      @(negedge clk);
    end
    vectors++; if (!finished) begin miscompares++;
      $display("FAIL run_timeout: outputs=%0d want %0d", nhs, M); end
  endtask

  task automatic test_stall();
    apply_reset();
    set_x(4);
    for (int i = 0; i < 63; i++) begin
      s_valid = (nacc < N);
      s_dat   = (nacc < N) ? xcur[nacc] : 0;
      m_ready = (i >= 61);
      #1;
      if (wr_en_x) nacc++;
      if (i == 33) begin
        vectors++; if (wr_en_y !== 1'b1) begin miscompares++;
          $display("FAIL stall_row0_write: wr_en_y=%b want 1", wr_en_y); end
      end
      if (i >= 51 && i <= 60) begin
        vectors++; if (wr_en_y !== 1'b0 || m_valid !== 1'b1 || int'(addr_w) !== 31 || int'(addr_b) !== 1) begin
          miscompares++;
          $display("FAIL stall_hold@%0d: wr_en_y=%b m_valid=%b addr_w=%0d addr_b=%0d want 0 1 31 1",
                   i, wr_en_y, m_valid, addr_w, addr_b); end
      end
      if (i == 61) begin
        vectors++; if (wr_en_y !== 1'b1 || m_valid !== 1'b1 || y !== y_exp(0)) begin miscompares++;
          $display("FAIL stall_release: wr_en_y=%b m_valid=%b y=%0d want 1 1 %0d", wr_en_y, m_valid, y, y_exp(0)); end
      end
      if (i == 62) begin
        vectors++; if (m_valid !== 1'b1 || y !== y_exp(1) || int'(addr_w) !== 32 || int'(addr_b) !== 2) begin
          miscompares++;
          $display("FAIL stall_after: m_valid=%b y=%0d addr_w=%0d addr_b=%0d want 1 %0d 32 2",
                   m_valid, y, addr_w, addr_b, y_exp(1)); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_toggle();
    apply_reset();
    set_x(7);
    m_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      s_valid = (i % 2 == 0);
      s_dat   = (nacc < N) ? xcur[nacc] : 0;
      #1;
      if (wr_en_x) begin
        vectors++; if (int'(addr_x) !== nacc || i !== 2 * nacc) begin miscompares++;
          $display("FAIL toggle_write@%0d: addr_x=%0d want %0d", i, addr_x, nacc); end
        nacc++;
      end
      if (i >= 31 && s_valid) begin
        vectors++; if (wr_en_x !== 1'b0 || s_ready !== 1'b0) begin miscompares++;
          $display("FAIL toggle_mac_ignore@%0d: wr_en_x=%b s_ready=%b want 0 0", i, wr_en_x, s_ready); end
      end
      if (i == 49) begin
        vectors++; if (m_valid !== 1'b1 || y !== y_exp(0)) begin miscompares++;
          $display("FAIL toggle_y0: m_valid=%b y=%0d want 1 %0d", m_valid, y, y_exp(0)); end
      end
      @(negedge clk);
    end
    vectors++; if (nacc !== N) begin miscompares++;
      $display("FAIL toggle_count: got %0d writes want %0d", nacc, N); end
  endtask

  task automatic test_reset_mid();
    bit hit = 0, got = 0;
    apply_reset();
    set_x(2);
    m_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      s_valid = 1'b1;
      s_dat   = (nacc < N) ? xcur[nacc] : 0;
      #1;
      if (wr_en_x) nacc++;
      if (busy && int'(addr_b) == 7 && int'(addr_w) == 7 * N + 4) begin hit = 1; break; end
      @(negedge clk);
    end
    vectors++; if (!hit) begin miscompares++;
      $display("FAIL midreset_reach_row7: never reached row 7 MAC"); end
    #2 reset = 1'b0;
    #1;
    vectors++; if (busy !== 1'b0 || m_valid !== 1'b0 || s_ready !== 1'b0 || wr_en_x !== 1'b0) begin miscompares++;
      $display("FAIL midreset_status: busy=%b m_valid=%b s_ready=%b wr_en_x=%b want 0 0 0 0",
               busy, m_valid, s_ready, wr_en_x); end
    vectors++; if (addr_x !== '0 || addr_w !== '0 || addr_b !== '0 || clear_acc !== 1'b0 || acc_en !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_regs: x=%0d w=%0d b=%0d clr=%b en=%b want all 0",
               addr_x, addr_w, addr_b, clear_acc, acc_en); end
    repeat (2) @(negedge clk);
    set_x(9);
    nacc  = 0;
    reset = 1'b1;
    for (int i = 0; i < 60; i++) begin
      s_valid = (nacc < N);
      s_dat   = (nacc < N) ? xcur[nacc] : 0;
      #1;
      if (i == 0) begin
        vectors++; if (wr_en_x !== 1'b1 || addr_x !== '0) begin miscompares++;
          $display("FAIL midreset_first_accept: wr_en_x=%b addr_x=%0d want 1 0", wr_en_x, addr_x); end
      end
      if (wr_en_x) nacc++;
      if (m_valid) begin
        vectors++; if (i !== 34 || y !== y_exp(0)) begin miscompares++;
          $display("FAIL midreset_row0: cycle=%0d y=%0d want 34 %0d", i, y, y_exp(0)); end
        got = 1;
        break;
      end
      @(negedge clk);
    end
    vectors++; if (!got) begin miscompares++;
      $display("FAIL midreset_timeout: no output after reload"); end
  endtask

  task automatic test_small();
    int na = 0, ca = -1, cv = -1, nhs = 0, last_hs = -1;
    bit checked_idle = 0;
    reset_s = 1'b0; s_valid_s = 1'b0; m_ready_s = 1'b1;
    repeat (3) @(negedge clk);
    reset_s = 1'b1;
    for (int i = 0; i < 40; i++) begin
      s_valid_s = (na < NS);
      #1;
      if (wr_en_x_s) begin
        vectors++; if (int'(addr_x_s) !== na) begin miscompares++;
          $display("FAIL small_load_addr: got %0d want %0d", addr_x_s, na); end
        na++;
        ca = i;
      end
      if (i == 9) begin
        vectors++; if (clear_acc_s !== 1'b1 || int'(addr_b_s) !== 1) begin miscompares++;
          $display("FAIL small_clear_row1: clear_acc=%b addr_b=%0d want 1 1", clear_acc_s, addr_b_s); end
      end
      if (i == 11) begin
        vectors++; if (acc_en_s !== 1'b1 || clear_acc_s !== 1'b0) begin miscompares++;
          $display("FAIL small_flush: acc_en=%b clear_acc=%b want 1 0", acc_en_s, clear_acc_s); end
      end
      if (i == 12) begin
        vectors++; if (wr_en_y_s !== 1'b1 || int'(addr_w_s) !== 5 || int'(addr_x_s) !== 2) begin miscompares++;
          $display("FAIL small_write_row1: wr_en_y=%b addr_w=%0d addr_x=%0d want 1 5 2", wr_en_y_s, addr_w_s, addr_x_s); end
      end
      if (nhs == MS && i == last_hs + 1) begin
        vectors++; if (s_ready_s !== 1'b1 || busy_s !== 1'b0) begin miscompares++;
          $display("FAIL small_back_to_load: s_ready=%b busy=%b want 1 0", s_ready_s, busy_s); end
        checked_idle = 1;
      end
      if (m_valid_s && cv < 0) begin
        cv = i;
        vectors++; if (cv - ca - 1 !== NS + 2) begin miscompares++;
          $display("FAIL small_latency: got %0d edges want %0d", cv - ca - 1, NS + 2); end
      end
      if (m_valid_s && m_ready_s) begin
        if (nhs > 0) begin
          vectors++; if (i - last_hs !== NS + 2 || busy_s !== 1'b1) begin miscompares++;
            $display("FAIL small_last_output: spacing=%0d busy=%b want %0d 1", i - last_hs, busy_s, NS + 2); end
        end
        last_hs = i;
        nhs++;
      end
      @(negedge clk);
    end
    vectors++; if (nhs !== MS || !checked_idle) begin miscompares++;
      $display("FAIL small_count: outputs=%0d want %0d", nhs, MS); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_s = 1'b0; s_valid_s = 1'b0; m_ready_s = 1'b0;
    nacc = 0; s_dat = 0;
    test_reset();
    test_full_run();
    test_stall();
    test_toggle();
    test_reset_mid();
    test_small();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
